// File: rtl/mul_shift_add_if.sv
// Operand/result bundle for mul_shift_add.
// master: requester driving start/a/b; slave: the multiplier.
interface mul_shift_add_if #(
    parameter int unsigned DATA_WIDTH = 448
);
    logic                      start;
    logic [DATA_WIDTH-1:0]     a;
    logic [DATA_WIDTH-1:0]     b;
    logic [2*DATA_WIDTH-1:0]   result;
    logic                      done;

    modport master (output start, output a, output b, input result, input done);
    modport slave  (input start, input a, input b, output result, output done);
endinterface

// File: rtl/mul_shift_add.sv
// Digit-serial shift-add unsigned multiplier, DATA_WIDTH x DATA_WIDTH -> 2*DATA_WIDTH.
// One DIGIT_WIDTH-bit multiplier digit is consumed per cycle; fixed latency N+1
// edges after the accepting start edge (N = DATA_WIDTH/DIGIT_WIDTH).
// Optional macro MUL_ZERO_SKIP_EN: finish early once the remaining multiplier
// (or the multiplicand) is zero. The product is identical either way.
module mul_shift_add #(
    parameter int unsigned DATA_WIDTH  = 448,
    parameter int unsigned DIGIT_WIDTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    mul_shift_add_if.slave    bus
);
    localparam int unsigned N   = DATA_WIDTH / DIGIT_WIDTH;
    localparam int unsigned CW  = $clog2(N + 1);
    localparam int unsigned PPW = DATA_WIDTH + DIGIT_WIDTH;
    localparam int unsigned RW  = 2 * DATA_WIDTH;

    if ((DATA_WIDTH % DIGIT_WIDTH) != 0) begin : g_width_check
        $error("DATA_WIDTH must be a multiple of DIGIT_WIDTH");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   mcand_q, mcand_d;
    logic [DATA_WIDTH-1:0]   mult_q, mult_d;
    logic [RW-1:0]           acc_q, acc_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [RW-1:0]           result_q, result_d;
    logic                    done_q, done_d;

    logic [DIGIT_WIDTH-1:0]  digit;
    logic [PPW-1:0]          pp;
    logic [RW-1:0]           pp_shifted;
    logic                    last;

    // Partial product of the current digit, aligned to its digit position.
    always_comb begin
        digit      = mult_q[DIGIT_WIDTH-1:0];
        pp         = PPW'(mcand_q) * PPW'(digit);
        pp_shifted = RW'(pp) << (32'(cnt_q) * DIGIT_WIDTH);
`ifdef MUL_ZERO_SKIP_EN
        // Nothing left to add once either factor's remaining part is zero.
        last = (cnt_q == CW'(N)) || (mult_q == '0) || (mcand_q == '0);
`else
        last = (cnt_q == CW'(N));
`endif
    end

    // Next-state and datapath update; every register holds by default.
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mult_d   = mult_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        done_d   = done_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    mcand_d = bus.a;
                    mult_d  = bus.b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    result_d = acc_q;
                    done_d   = 1'b1;
                    state_d  = DONE;
                end else begin
                    acc_d  = acc_q + pp_shifted;
                    mult_d = mult_q >> DIGIT_WIDTH;
                    cnt_d  = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mult_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mult_q   <= mult_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign bus.result = result_q;
    assign bus.done   = done_q;
endmodule

// File: tb/tb_mul_shift_add.sv
// Directed-vector bench for mul_shift_add with closed-form expected products.
module tb_mul_shift_add;
    localparam int unsigned DW = 448;
    localparam int unsigned DG = 16;
    localparam int unsigned N  = DW / DG;
    localparam int unsigned RW = 2 * DW;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mul_shift_add_if #(.DATA_WIDTH(DW)) bus ();

    mul_shift_add #(.DATA_WIDTH(DW), .DIGIT_WIDTH(DG)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int unsigned checks = 0;
    int unsigned errors = 0;

    task automatic check(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Pulse start for one cycle, then count edges after the accepting edge until done.
    task automatic run_op(input logic [DW-1:0] a, input logic [DW-1:0] b, output int unsigned lat);
        @(negedge clk);
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = ~a;
        bus.b     = ~b;
        check("done_fall", RW'(bus.done), '0);
        lat = 0;
        while (!bus.done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    logic [DW-1:0] a_big, b_big, a_s, b_near;
    logic [RW-1:0] e_big, e_small, e_near;
    int unsigned   lat, lat_zero, lat_small;

    initial begin
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;

        // a = 2^446 + 2^225 - 2, b = 2^448 - 2^224 - 1
        a_big  = (DW'(1) << 446) + (DW'(1) << 225) - DW'(2);
        b_big  = '1;
        b_big  = b_big - (DW'(1) << 224);
        e_big  = (RW'(1) << 894) + (RW'(1) << 673) - (RW'(1) << 670)
               - (RW'(1) << 450) - (RW'(1) << 446) + RW'(2);
        // a = 2^445 - 1
        a_s    = '1;
        a_s    = a_s >> 3;
        e_small = (RW'(1) << 446) + (RW'(1) << 445) - RW'(3);
        b_near = a_s - DW'(1);
        e_near = (RW'(1) << 890) - (RW'(3) << 445) + RW'(2);
`ifdef MUL_ZERO_SKIP_EN
        lat_zero  = 1;
        lat_small = 2;
`else
        lat_zero  = N + 1;
        lat_small = N + 1;
`endif

        #12;
        check("rst_result", bus.result, '0);
        check("rst_done", RW'(bus.done), '0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_done", RW'(bus.done), '0);

        run_op(a_big, b_big, lat);
        check("big_lat", RW'(lat), RW'(N + 1));
        check("big_done", RW'(bus.done), RW'(1));
        check("big_res", bus.result, e_big);
        repeat (3) @(negedge clk);
        check("hold_done", RW'(bus.done), RW'(1));
        check("hold_res", bus.result, e_big);

        run_op(a_s, DW'(3), lat);
        check("small_lat", RW'(lat), RW'(lat_small));
        check("small_res", bus.result, e_small);
        check("small_hi", RW'(bus.result[RW-1:DW]), '0);

        run_op(a_s, b_near, lat);
        check("near_lat", RW'(lat), RW'(N + 1));
        check("near_res", bus.result, e_near);

        run_op('0, '1, lat);
        check("zero_lat", RW'(lat), RW'(lat_zero));
        check("zero_done", RW'(bus.done), RW'(1));
        check("zero_res", bus.result, '0);

        // Second start mid-run must be ignored.
        @(negedge clk);
        bus.a = a_big; bus.b = b_big; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        bus.a = a_s; bus.b = DW'(3); bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 5;
        while (!bus.done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("ign_lat", RW'(lat), RW'(N + 1));
        check("ign_res", bus.result, e_big);

        // Reset mid-run clears outputs without a clock edge.
        @(negedge clk);
        bus.a = a_s; bus.b = b_near; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("mrst_done", RW'(bus.done), '0);
        check("mrst_res", bus.result, '0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(a_s, DW'(3), lat);
        check("post_lat", RW'(lat), RW'(lat_small));
        check("post_res", bus.result, e_small);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
